// File: rtl/minibus_pkg.sv
// Shared minibus definitions: bus widths, access-width encodings,
// master state encoding and the alignment rule.
package minibus_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } master_state_t;

  // A request is misaligned if its width is illegal or the address is not
  // a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (width)
      WIDTH_BYTE: bad = 1'b0;
      WIDTH_HALF: bad = addr_lo[0];
      WIDTH_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/minibus_rdata_extend.sv
// Zero/sign extension of low-aligned minibus read data to the full
// data width according to the access width.
module minibus_rdata_extend
  import minibus_pkg::*;
(
  input  logic [1:0]            width,
  input  logic                  uns,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ext
);

  logic signed [7:0]            byte_s;
  logic signed [15:0]           half_s;
  logic signed [DATA_WIDTH-1:0] byte_sx;
  logic signed [DATA_WIDTH-1:0] half_sx;

  assign byte_s  = $signed(rdata[7:0]);
  assign half_s  = $signed(rdata[15:0]);
  // Signed-to-signed assignment performs the sign extension.
  assign byte_sx = byte_s;
  assign half_sx = half_s;

  // Select the extended value for the access width; bits above it are ignored.
  always_comb begin
    ext = rdata;
    case (width)
      WIDTH_BYTE: ext = uns ? {{(DATA_WIDTH-8){1'b0}}, rdata[7:0]}
                            : byte_sx;
      WIDTH_HALF: ext = uns ? {{(DATA_WIDTH-16){1'b0}}, rdata[15:0]}
                            : half_sx;
      default:    ext = rdata;
    endcase
  end

endmodule

// File: rtl/minibus_master_port.sv
// Minibus initiator: accepts one core load/store at a time, holds it on the
// bus until ack/err or timeout, and returns a single registered response.
module minibus_master_port
  import minibus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_wen,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [1:0]            cpu_width,
  input  logic                  cpu_unsigned,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_res_valid,
  output logic                  cpu_res_err,
  output logic                  cpu_res_timeout,
  output logic [DATA_WIDTH-1:0] cpu_res_rdata,
  output logic                  bus_wen,
  output logic                  bus_ren,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [1:0]            bus_width,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  master_state_t         state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_wen;
  logic                  lat_uns;
  logic [DATA_WIDTH-1:0] ext_rdata;
  logic                  tmo_hit;

  // bus_width and lat_uns hold the latched request for the whole BUS state.
  minibus_rdata_extend u_extend (
    .width (bus_width),
    .uns   (lat_uns),
    .rdata (bus_rdata),
    .ext   (ext_rdata)
  );

  assign cpu_req_ready = (state == IDLE);
  assign tmo_hit       = (cnt == CNT_LAST);

  // Request/response FSM; every bus_* and cpu_res_* output is a register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= IDLE;
      cnt             <= '0;
      lat_wen         <= 1'b0;
      lat_uns         <= 1'b0;
      bus_wen         <= 1'b0;
      bus_ren         <= 1'b0;
      bus_addr        <= '0;
      bus_width       <= '0;
      bus_wdata       <= '0;
      cpu_res_valid   <= 1'b0;
      cpu_res_err     <= 1'b0;
      cpu_res_timeout <= 1'b0;
      cpu_res_rdata   <= '0;
    end else begin
      cpu_res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_valid) begin
            lat_wen <= cpu_wen;
            lat_uns <= cpu_unsigned;
            cnt     <= '0;
            if (is_misaligned(cpu_width, cpu_addr[1:0])) begin
              // Local error: the request never appears on the bus.
              state           <= RESP;
              cpu_res_valid   <= 1'b1;
              cpu_res_err     <= 1'b1;
              cpu_res_timeout <= 1'b0;
              cpu_res_rdata   <= '0;
            end else begin
              state     <= BUS;
              bus_addr  <= cpu_addr;
              bus_width <= cpu_width;
              bus_wdata <= cpu_wdata;
              bus_wen   <= cpu_wen;
              bus_ren   <= ~cpu_wen;
            end
          end
        end
        BUS: begin
          cnt <= cnt + 1'b1;
          if (bus_err || bus_ack || tmo_hit) begin
            state           <= RESP;
            bus_wen         <= 1'b0;
            bus_ren         <= 1'b0;
            cpu_res_valid   <= 1'b1;
            // err dominates ack; timeout only when neither arrived.
            cpu_res_err     <= bus_err || !bus_ack;
            cpu_res_timeout <= !bus_err && !bus_ack;
            cpu_res_rdata   <= (!bus_err && bus_ack && !lat_wen) ? ext_rdata : '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minibus_master_port.sv
// Directed bench for minibus_master_port with a 4-register one-wait-state slave.
module tb_minibus_master_port;
  import minibus_pkg::*;

  logic                  clk = 1'b0;
  logic                  nrst = 1'b0;
  logic                  cpu_req_valid = 1'b0;
  logic                  cpu_req_ready;
  logic                  cpu_wen = 1'b0;
  logic [ADDR_WIDTH-1:0] cpu_addr = '0;
  logic [1:0]            cpu_width = 2'b00;
  logic                  cpu_unsigned = 1'b0;
  logic [DATA_WIDTH-1:0] cpu_wdata = '0;
  logic                  cpu_res_valid;
  logic                  cpu_res_err;
  logic                  cpu_res_timeout;
  logic [DATA_WIDTH-1:0] cpu_res_rdata;
  logic                  bus_wen;
  logic                  bus_ren;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [1:0]            bus_width;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic                  bus_err;
  logic [DATA_WIDTH-1:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  // slave model
  logic        slave_en = 1'b1;
  logic        force_err = 1'b0;
  logic [31:0] regs [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic [7:0]  wcnt = 8'd0;
  logic        strobe;

  always #5 clk = ~clk;

  minibus_master_port #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_width(cpu_width),
    .cpu_unsigned(cpu_unsigned), .cpu_wdata(cpu_wdata),
    .cpu_res_valid(cpu_res_valid), .cpu_res_err(cpu_res_err),
    .cpu_res_timeout(cpu_res_timeout), .cpu_res_rdata(cpu_res_rdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
    .bus_width(bus_width), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  assign strobe    = bus_wen | bus_ren;
  assign bus_ack   = (slave_en || force_err) && strobe && (wcnt == 8'd1);
  assign bus_err   = force_err && strobe && (wcnt == 8'd1);
  assign bus_rdata = regs[bus_addr[3:2]] >> (8 * bus_addr[1:0]);

  always @(posedge clk) begin
    wcnt <= strobe ? wcnt + 8'd1 : 8'd0;
    if (bus_ack && !bus_err && bus_wen) begin
      case (bus_width)
        WIDTH_BYTE: regs[bus_addr[3:2]][8*bus_addr[1:0] +: 8] <= bus_wdata[7:0];
        WIDTH_HALF: regs[bus_addr[3:2]][16*bus_addr[1] +: 16] <= bus_wdata[15:0];
        default:    regs[bus_addr[3:2]] <= bus_wdata;
      endcase
    end
  end

  // Issue one request; report response fields, cycle of cpu_res_valid
  // (accept = cycle 0), strobe cycle counts and post-response status.
  task automatic do_req(input logic wen, input logic [31:0] addr,
                        input logic [1:0] width, input logic uns,
                        input logic [31:0] wdata,
                        output int lat, output int nw, output int nr,
                        output logic err, output logic tmo,
                        output logic [31:0] rdata,
                        output logic ready_after, output logic valid_after);
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_wen = wen; cpu_addr = addr;
    cpu_width = width; cpu_unsigned = uns; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    lat = -1; nw = 0; nr = 0; err = 1'b0; tmo = 1'b0; rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_wen) nw++;
      if (bus_ren) nr++;
      if (cpu_res_valid) begin
        lat = k; err = cpu_res_err; tmo = cpu_res_timeout; rdata = cpu_res_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ready_after = cpu_req_ready;
    valid_after = cpu_res_valid;
  endtask

  task automatic test_reset();
    #1;
    checks++; if ({bus_wen, bus_ren, cpu_res_valid, cpu_res_err, cpu_res_timeout} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {bus_wen, bus_ren, cpu_res_valid, cpu_res_err, cpu_res_timeout}); end
    checks++; if ({bus_addr, bus_wdata, cpu_res_rdata} !== 96'h0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {bus_addr, bus_wdata, cpu_res_rdata}); end
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cpu_req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", cpu_req_ready); end
  endtask

  task automatic test_word_rw();
    int lat, nw, nr; logic err, tmo, ra, va; logic [31:0] rd;
    do_req(1'b1, 32'h8, WIDTH_WORD, 1'b0, 32'hDEADBEEF, lat, nw, nr, err, tmo, rd, ra, va);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    checks++; if (nw !== 2 || nr !== 0) begin failures++; $display("FAIL wr_strobes got=w%0d r%0d exp=w2 r0", nw, nr); end
    checks++; if (err !== 1'b0 || tmo !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL wr_resp got=err%b tmo%b rd%h exp=err0 tmo0 rd0", err, tmo, rd); end
    checks++; if (ra !== 1'b1 || va !== 1'b0) begin
      failures++; $display("FAIL wr_after got=ready%b valid%b exp=ready1 valid0", ra, va); end
    do_req(1'b0, 32'h8, WIDTH_WORD, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    checks++; if (lat !== 3 || nr !== 2 || nw !== 0) begin
      failures++; $display("FAIL rd_timing got=lat%0d r%0d w%0d exp=lat3 r2 w0", lat, nr, nw); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
      failures++; $display("FAIL rd_word got=%h err%b exp=deadbeef err0", rd, err); end
  endtask

  task automatic test_extend();
    int lat, nw, nr; logic err, tmo, ra, va; logic [31:0] rd;
    logic [31:0] exp_tab [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF,
                                 32'hFFFF80FF, 32'h000080FF, 32'h00007FFF};
    logic [31:0] addr_tab [6] = '{32'h9, 32'h9, 32'h8, 32'h8, 32'h8, 32'h2};
    logic [1:0]  wid_tab [6] = '{WIDTH_BYTE, WIDTH_BYTE, WIDTH_BYTE,
                                 WIDTH_HALF, WIDTH_HALF, WIDTH_HALF};
    logic        uns_tab [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_req(1'b1, 32'h8, WIDTH_WORD, 1'b0, 32'h000080FF, lat, nw, nr, err, tmo, rd, ra, va);
    do_req(1'b1, 32'h0, WIDTH_WORD, 1'b0, 32'h7FFF0000, lat, nw, nr, err, tmo, rd, ra, va);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, addr_tab[i], wid_tab[i], uns_tab[i], 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
      checks++; if (rd !== exp_tab[i] || err !== 1'b0) begin
        failures++; $display("FAIL extend_%0d got=%h err%b exp=%h err0", i, rd, err, exp_tab[i]); end
    end
  endtask

  task automatic test_misaligned();
    int lat, nw, nr; logic err, tmo, ra, va; logic [31:0] rd;
    do_req(1'b1, 32'h3, WIDTH_HALF, 1'b0, 32'h1234, lat, nw, nr, err, tmo, rd, ra, va);
    checks++; if (lat !== 1 || err !== 1'b1 || tmo !== 1'b0) begin
      failures++; $display("FAIL misalign_half got=lat%0d err%b tmo%b exp=lat1 err1 tmo0", lat, err, tmo); end
    checks++; if (nw !== 0 || nr !== 0) begin
      failures++; $display("FAIL misalign_strobes got=w%0d r%0d exp=w0 r0", nw, nr); end
    do_req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    checks++; if (lat !== 1 || err !== 1'b1 || nr !== 0 || rd !== 32'h0) begin
      failures++; $display("FAIL width11 got=lat%0d err%b r%0d rd%h exp=lat1 err1 r0 rd0", lat, err, nr, rd); end
    do_req(1'b0, 32'h6, WIDTH_WORD, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    checks++; if (lat !== 1 || err !== 1'b1 || nr !== 0) begin
      failures++; $display("FAIL misalign_word got=lat%0d err%b r%0d exp=lat1 err1 r0", lat, err, nr); end
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL misalign_ready got=%b exp=1", ra); end
  endtask

  task automatic test_err_ack();
    int lat, nw, nr; logic err, tmo, ra, va; logic [31:0] rd;
    // Leaves cpu_res_rdata non-zero so the zeroing on error is visible.
    do_req(1'b0, 32'h8, WIDTH_WORD, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    force_err = 1'b1;
    do_req(1'b0, 32'h8, WIDTH_WORD, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    force_err = 1'b0;
    checks++; if (lat !== 3 || err !== 1'b1 || tmo !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL err_ack got=lat%0d err%b tmo%b rd%h exp=lat3 err1 tmo0 rd0", lat, err, tmo, rd); end
  endtask

  task automatic test_timeout();
    int lat, nw, nr; logic err, tmo, ra, va; logic [31:0] rd;
    slave_en = 1'b0;
    do_req(1'b0, 32'h4, WIDTH_WORD, 1'b0, 32'h0, lat, nw, nr, err, tmo, rd, ra, va);
    slave_en = 1'b1;
    checks++; if (nr !== 16 || lat !== 17) begin
      failures++; $display("FAIL timeout_cycles got=r%0d lat%0d exp=r16 lat17", nr, lat); end
    checks++; if (err !== 1'b1 || tmo !== 1'b1) begin
      failures++; $display("FAIL timeout_flags got=err%b tmo%b exp=err1 tmo1", err, tmo); end
    checks++; if (ra !== 1'b1 || va !== 1'b0) begin
      failures++; $display("FAIL timeout_after got=ready%b valid%b exp=ready1 valid0", ra, va); end
  endtask

  task automatic test_reset_in_bus();
    int stray;
    slave_en = 1'b0;
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h4; cpu_width = WIDTH_WORD;
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    checks++; if (bus_ren !== 1'b1) begin failures++; $display("FAIL rib_start got=%b exp=1", bus_ren); end
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b0; #1;
    checks++; if (bus_ren !== 1'b0 || bus_wen !== 1'b0) begin
      failures++; $display("FAIL rib_strobes got=w%b r%b exp=w0 r0", bus_wen, bus_ren); end
    slave_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cpu_req_ready !== 1'b1) begin failures++; $display("FAIL rib_ready got=%b exp=1", cpu_req_ready); end
    stray = 0;
    for (int k = 0; k < 20; k++) begin
      if (cpu_res_valid || strobe) stray++;
      @(posedge clk); #1;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rib_stray got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_extend();
    test_misaligned();
    test_err_ack();
    test_timeout();
    test_reset_in_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minibus_master_port.md
Name: minibus_master_port

Overview:
- Initiator end of minibus. Turns single load/store requests from a core-side LSU or DMA into minibus request phases.
- Holds each request stable until the slave responds with ack or err, or until a timeout expires.
- Zero- or sign-extends narrow read data and returns one response per request.
- Sits between the core memory stage and the minibus address decoder. The decoder drives each slave's sel.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUS-state cycles before the request is aborted with a timeout error. Must be ≥2.
- DATA_WIDTH, 32: taken from minibus_pkg and not overridden.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- cpu_req_valid  input  1  core presents a request
- cpu_req_ready  output  1  port can accept a request (high only in IDLE)
- cpu_wen  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_WIDTH  byte address
- cpu_width  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- cpu_unsigned  input  1  read data zero-extended when 1, sign-extended when 0
- cpu_wdata  input  DATA_WIDTH  write data, low-aligned
- cpu_res_valid  output  1  one-cycle response pulse
- cpu_res_err  output  1  bus error, misalignment or timeout
- cpu_res_timeout  output  1  error caused by timeout
- cpu_res_rdata  output  DATA_WIDTH  extended read data (0 for writes and errors)
- bus_wen, bus_ren  output  1 each  minibus request strobes
- bus_addr  output  ADDR_WIDTH  request address
- bus_width  output  2  request width
- bus_wdata  output  DATA_WIDTH  request write data
- bus_ack, bus_err  input  1 each  minibus response
- bus_rdata  input  DATA_WIDTH  minibus read data, low-aligned

Behaviour:
- Reset: state IDLE. All bus_* outputs, cpu_res_* outputs, latched request and counter are 0. cpu_req_ready is 1 after reset release.
- State machine: IDLE, BUS, RESP. All bus_* and cpu_res_* outputs are registered.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch wen/addr/width/unsigned/wdata.
  - Misaligned requests are locally errored and never reach the bus. Misaligned means: width=11; or half with addr[0]=1; or word with addr[1:0]≠00. These go to RESP with err=1.
  - All other requests go to BUS.
- BUS:
  - bus_wen = latched wen and bus_ren = ~latched wen. addr, width and wdata are driven from the latch and held stable for the whole state.
  - Counter starts at 0 and increments each cycle.
  - If bus_err=1, go to RESP with err=1. err wins over a simultaneous ack.
  - Else if bus_ack=1, go to RESP. For reads, capture the extended bus_rdata.
  - Else if counter = TIMEOUT_CYCLES-1, go to RESP with err=1 and timeout=1.
- RESP:
  - cpu_res_valid = 1 for exactly one cycle. bus_wen and bus_ren are 0.
  - This mandatory idle cycle on the bus prevents a registered slave from re-triggering on a held request.
  - Next state is IDLE.
  - cpu_res_* hold their values until the next RESP. Only valid pulses.
- Read extension:
  - byte: bits [7:0], extended with bit 7 (signed) or 0 (unsigned).
  - half: bits [15:0], extended with bit 15 (signed) or 0 (unsigned).
  - word: passed through unchanged.
  - Bits above the width are ignored.
- Latency with a one-wait-state slave (ack in second BUS cycle):
  - Accept in cycle 0, BUS in cycles 1-2, cpu_res_valid in cycle 3, ready again in cycle 4.
  - Misaligned requests: cpu_res_valid in cycle 1.
- ack or err arriving while in IDLE or RESP is ignored.
- cpu_req_valid in BUS or RESP is not accepted; ready=0 there.
- Asynchronous reset in BUS drops bus strobes immediately and no response is issued.

Decomposition:
- minibus_pkg gains:
  - width encodings (WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10);
  - the master state enum (IDLE/BUS/RESP);
  - a misalignment check function.
- One sub-module, minibus_rdata_extend: a combinational extender with inputs width, unsigned and rdata, and output the extended data.

Test Plan:
- Word write, addr 0x8, wdata 0xDEADBEEF, to minibus_slave_regs (4 regs) -> bus_wen held for 2 cycles, cpu_res_valid in cycle 3 with err=0; a subsequent word read of 0x8 returns 0xDEADBEEF.
- Byte read, addr 0x9, signed, register holding 0x0000_80FF -> rdata 0xFFFFFF80. Same read unsigned -> 0x00000080.
- Half read, addr 0x2, signed, register holding 0x7FFF_0000 -> 0x00007FFF. Half write with addr 0x3 -> err=1 in cycle 1 and no bus_wen/bus_ren pulse.
- Width 2'b11 -> local err. A slave forced to return bus_err and bus_ack in the same cycle -> err=1, rdata=0.
- No slave selected (ack never rises), TIMEOUT_CYCLES=16 -> exactly 16 BUS cycles, then err=1 and timeout=1, then ready.
- Assert nrst low during BUS -> bus strobes at 0 immediately; after release, cpu_req_ready=1 and no stray cpu_res_valid.
